// File: rtl/rfm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rfm_pkg
// Description : Shared constants and state encoding for the refresh-management
//               request scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rfm_pkg;

    // Number of request slots and the index width that addresses them
    localparam int N    = 64;
    localparam int LOGN = 6;

    // Legal range of the downstream encoder latency
    localparam int PE_LAT_MIN = 0;
    localparam int PE_LAT_MAX = 7;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_OFFER = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rfm_pend_bitmap.sv
`default_nettype none
// ============================================================================
// Module      : rfm_pend_bitmap
// Description : Pending-request bitmap with a running population count.
//               A set and a clear of the same slot in one cycle leaves the
//               slot pending; flush empties everything.
// Revision    : 1.0 - initial release
// ============================================================================
module rfm_pend_bitmap
    import rfm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_vld,
    input  logic [LOGN-1:0] set_idx,
    input  logic            clr_vld,
    input  logic [LOGN-1:0] clr_idx,
    input  logic            flush,
    output logic [N-1:0]    pend,
    output logic [LOGN:0]   pend_cnt
);

    logic [N-1:0]  r_pend;
    logic [LOGN:0] r_cnt;
    logic [N-1:0]  w_setMask;
    logic [N-1:0]  w_clrMask;
    logic          w_inc;
    logic          w_dec;

    // Decode the set/clear strobes and decide the count step; the count only
    // moves when the bit really changes, so it can neither overflow nor underflow
    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        if (set_vld) w_setMask[set_idx] = 1'b1;
        if (clr_vld) w_clrMask[clr_idx] = 1'b1;
        w_inc = set_vld & ~r_pend[set_idx];
        w_dec = clr_vld & r_pend[clr_idx] & ~(set_vld & (set_idx == clr_idx));
    end

    // Bitmap and count registers; set is OR-ed after the clear so set wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clrMask) | w_setMask;
            r_cnt  <= r_cnt + {{LOGN{1'b0}}, w_inc} - {{LOGN{1'b0}}, w_dec};
        end
    end

    assign pend     = r_pend;
    assign pend_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/rfm_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : rfm_req_sched
// Description : Grant sequencer for 64 RFM request slots. Launches a snapshot
//               of the pending bitmap into an external pipelined priority
//               encoder, waits its fixed latency, validates the answer and
//               offers the winning slot on a valid/ready grant port.
// Revision    : 1.0 - initial release
// ============================================================================
module rfm_req_sched
    import rfm_pkg::*;
#(
    parameter int PE_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_vld,
    input  logic [LOGN-1:0] set_idx,
    input  logic            clr_all,
    output logic [N-1:0]    pe_oht,
    input  logic [LOGN-1:0] pe_bin,
    input  logic            pe_vld,
    output logic            gnt_vld,
    output logic [LOGN-1:0] gnt_idx,
    input  logic            gnt_rdy,
    output logic [LOGN:0]   pend_cnt,
    output logic            busy,
    output logic            err
);

    localparam logic [2:0] c_peLat = 3'(PE_LAT);

    if ((PE_LAT < PE_LAT_MIN) || (PE_LAT > PE_LAT_MAX)) begin : g_pe_lat_range
        $error("rfm_req_sched: PE_LAT out of range");
    end

    state_t          r_state;
    logic [2:0]      r_latCnt;
    logic [N-1:0]    r_peOht;
    logic            r_gntVld;
    logic [LOGN-1:0] r_gntIdx;
    logic            r_err;
    logic [N-1:0]    w_pend;
    logic            w_handshake;

    assign w_handshake = (r_state == ST_OFFER) & r_gntVld & gnt_rdy;

    rfm_pend_bitmap u_pend (
        .clk      (clk),
        .rst      (rst),
        .set_vld  (set_vld),
        .set_idx  (set_idx),
        .clr_vld  (w_handshake),
        .clr_idx  (r_gntIdx),
        .flush    (clr_all),
        .pend     (w_pend),
        .pend_cnt (pend_cnt)
    );

    // Launch / wait / offer sequencer; flush abandons any in-flight work but
    // leaves the last snapshot and the sticky error untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_latCnt <= '0;
            r_peOht  <= '0;
            r_gntVld <= 1'b0;
            r_gntIdx <= '0;
            r_err    <= 1'b0;
        end else if (clr_all) begin
            r_state  <= ST_IDLE;
            r_gntVld <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_pend) begin
                        r_peOht  <= w_pend;
                        r_latCnt <= '0;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_latCnt == c_peLat) begin
                        // Only trust an answer that points at a bit we sent
                        if (pe_vld && r_peOht[pe_bin]) begin
                            r_gntIdx <= pe_bin;
                            r_gntVld <= 1'b1;
                            r_state  <= ST_OFFER;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_latCnt <= r_latCnt + 3'd1;
                    end
                end
                ST_OFFER: begin
                    if (r_gntVld && gnt_rdy) begin
                        r_gntVld <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pe_oht  = r_peOht;
    assign gnt_vld = r_gntVld;
    assign gnt_idx = r_gntIdx;
    assign err     = r_err;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rfm_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rfm_req_sched
// Description : Directed self-checking bench for rfm_req_sched, wrapped
//               around a behavioural lowest-index encoder of PE_LAT stages.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rfm_req_sched;
    import rfm_pkg::*;

    localparam int PE_LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            set_vld = 1'b0;
    logic [LOGN-1:0] set_idx = '0;
    logic            clr_all = 1'b0;
    logic [N-1:0]    pe_oht;
    logic [LOGN-1:0] pe_bin;
    logic            pe_vld;
    logic            gnt_vld;
    logic [LOGN-1:0] gnt_idx;
    logic            gnt_rdy = 1'b0;
    logic [LOGN:0]   pend_cnt;
    logic            busy;
    logic            err;
    logic            forceBad = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Free-running cycle stamp for spacing measurements
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural encoder: lowest set index, then PE_LAT register stages
    logic [LOGN-1:0] encBin;
    logic            encVld;
    logic [LOGN-1:0] binPipe [PE_LAT];
    logic            vldPipe [PE_LAT];

    always_comb begin
        encBin = '0;
        encVld = (pe_oht != '0);
        for (int i = N - 1; i >= 0; i--) if (pe_oht[i]) encBin = LOGN'(i);
    end

    always @(posedge clk) begin
        binPipe[0] <= encBin;
        vldPipe[0] <= encVld;
        for (int i = 1; i < PE_LAT; i++) begin
            binPipe[i] <= binPipe[i-1];
            vldPipe[i] <= vldPipe[i-1];
        end
    end

    assign pe_bin = binPipe[PE_LAT-1];
    assign pe_vld = vldPipe[PE_LAT-1] & ~forceBad;

    rfm_req_sched #(.PE_LAT(PE_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_vld  (set_vld),
        .set_idx  (set_idx),
        .clr_all  (clr_all),
        .pe_oht   (pe_oht),
        .pe_bin   (pe_bin),
        .pe_vld   (pe_vld),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx),
        .gnt_rdy  (gnt_rdy),
        .pend_cnt (pend_cnt),
        .busy     (busy),
        .err      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input logic [LOGN-1:0] idx);
        set_vld = 1'b1;
        set_idx = idx;
        tick();
        set_vld = 1'b0;
    endtask

    // Advance until a grant is offered or the budget runs out
    task automatic wait_gnt(input int maxCyc, output bit ok, output int stamp);
        ok = 1'b0;
        stamp = 0;
        for (int i = 0; i < maxCyc; i++) begin
            if (gnt_vld) begin
                ok = 1'b1;
                stamp = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pe_oht !== '0) begin errors++; $display("FAIL reset_pe_oht: got %h expected 0", pe_oht); end
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL reset_gnt_vld: got %b expected 0", gnt_vld); end
        checks++; if (gnt_idx !== '0) begin errors++; $display("FAIL reset_gnt_idx: got %0d expected 0", gnt_idx); end
        checks++; if (pend_cnt !== '0) begin errors++; $display("FAIL reset_pend_cnt: got %0d expected 0", pend_cnt); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got %b%b expected 00", busy, err); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b expected 0", busy); end
    endtask

    task automatic test_single();
        logic [N-1:0] expOht;
        expOht = '0;
        expOht[37] = 1'b1;
        gnt_rdy = 1'b1;
        set_slot(6'd37);
        checks++; if (pend_cnt !== 7'd1 || gnt_vld !== 1'b0) begin errors++; $display("FAIL single_set: cnt %0d vld %b expected 1 0", pend_cnt, gnt_vld); end
        tick();
        checks++; if (pe_oht !== expOht || busy !== 1'b1) begin errors++; $display("FAIL single_snapshot: got %h busy %b expected %h 1", pe_oht, busy, expOht); end
        for (int i = 0; i < PE_LAT; i++) begin
            tick();
            checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL single_early_gnt: cycle L+%0d got 1 expected 0", i + 1); end
        end
        tick();
        checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 6'd37) begin errors++; $display("FAIL single_gnt: vld %b idx %0d expected 1 37", gnt_vld, gnt_idx); end
        checks++; if (pend_cnt !== 7'd1) begin errors++; $display("FAIL single_cnt_offer: got %0d expected 1", pend_cnt); end
        tick();
        checks++; if (gnt_vld !== 1'b0 || pend_cnt !== 7'd0) begin errors++; $display("FAIL single_done: vld %b cnt %0d expected 0 0", gnt_vld, pend_cnt); end
    endtask

    task automatic test_ordering();
        bit ok;
        int stamp;
        int prev;
        logic [LOGN-1:0] expIdx [3];
        expIdx[0] = 6'd0;
        expIdx[1] = 6'd5;
        expIdx[2] = 6'd63;
        prev = 0;
        // Park a grant so the burst lands in the bitmap before the next launch
        gnt_rdy = 1'b0;
        set_slot(6'd20);
        wait_gnt(20, ok, stamp);
        checks++; if (!ok || gnt_idx !== 6'd20) begin errors++; $display("FAIL order_prime: ok %0d idx %0d expected 1 20", ok, gnt_idx); end
        set_slot(6'd5);
        set_slot(6'd0);
        set_slot(6'd63);
        checks++; if (pend_cnt !== 7'd4 || gnt_idx !== 6'd20) begin errors++; $display("FAIL order_burst: cnt %0d idx %0d expected 4 20", pend_cnt, gnt_idx); end
        gnt_rdy = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            wait_gnt(20, ok, stamp);
            checks++; if (!ok || gnt_idx !== expIdx[k]) begin errors++; $display("FAIL order_idx%0d: ok %0d idx %0d expected %0d", k, ok, gnt_idx, expIdx[k]); end
            checks++; if (pend_cnt !== 7'(3 - k)) begin errors++; $display("FAIL order_cnt%0d: got %0d expected %0d", k, pend_cnt, 3 - k); end
            if (k > 0) begin
                checks++; if (stamp - prev != PE_LAT + 3) begin errors++; $display("FAIL order_spacing%0d: got %0d expected %0d", k, stamp - prev, PE_LAT + 3); end
            end
            prev = stamp;
            tick();
        end
        checks++; if (pend_cnt !== 7'd0) begin errors++; $display("FAIL order_empty: got %0d expected 0", pend_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        int stamp;
        gnt_rdy = 1'b0;
        set_slot(6'd10);
        wait_gnt(20, ok, stamp);
        checks++; if (!ok || gnt_idx !== 6'd10) begin errors++; $display("FAIL bp_first: ok %0d idx %0d expected 1 10", ok, gnt_idx); end
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_vld = (i == 2);
            set_idx = 6'd2;
            tick();
            if (gnt_vld !== 1'b1 || gnt_idx !== 6'd10) stable = 1'b0;
        end
        set_vld = 1'b0;
        checks++; if (!stable) begin errors++; $display("FAIL bp_stable: got %b/%0d expected 1/10", gnt_vld, gnt_idx); end
        checks++; if (pend_cnt !== 7'd2) begin errors++; $display("FAIL bp_cnt: got %0d expected 2", pend_cnt); end
        gnt_rdy = 1'b1;
        tick();
        checks++; if (gnt_vld !== 1'b0 || pend_cnt !== 7'd1) begin errors++; $display("FAIL bp_accept: vld %b cnt %0d expected 0 1", gnt_vld, pend_cnt); end
        wait_gnt(20, ok, stamp);
        checks++; if (!ok || gnt_idx !== 6'd2) begin errors++; $display("FAIL bp_second: ok %0d idx %0d expected 1 2", ok, gnt_idx); end
        tick();
        checks++; if (pend_cnt !== 7'd0) begin errors++; $display("FAIL bp_empty: got %0d expected 0", pend_cnt); end
    endtask

    task automatic test_set_wins();
        bit ok;
        int stamp;
        gnt_rdy = 1'b0;
        set_slot(6'd10);
        wait_gnt(20, ok, stamp);
        checks++; if (!ok || gnt_idx !== 6'd10 || pend_cnt !== 7'd1) begin errors++; $display("FAIL sw_first: ok %0d idx %0d cnt %0d expected 1 10 1", ok, gnt_idx, pend_cnt); end
        gnt_rdy = 1'b1;
        set_slot(6'd10);
        checks++; if (gnt_vld !== 1'b0 || pend_cnt !== 7'd1) begin errors++; $display("FAIL sw_handshake: vld %b cnt %0d expected 0 1", gnt_vld, pend_cnt); end
        gnt_rdy = 1'b0;
        wait_gnt(20, ok, stamp);
        checks++; if (!ok || gnt_idx !== 6'd10) begin errors++; $display("FAIL sw_regrant: ok %0d idx %0d expected 1 10", ok, gnt_idx); end
        // A different slot set on the handshake leaves the count unchanged
        gnt_rdy = 1'b1;
        set_slot(6'd11);
        checks++; if (pend_cnt !== 7'd1) begin errors++; $display("FAIL sw_other_cnt: got %0d expected 1", pend_cnt); end
        wait_gnt(20, ok, stamp);
        checks++; if (!ok || gnt_idx !== 6'd11) begin errors++; $display("FAIL sw_other_gnt: ok %0d idx %0d expected 1 11", ok, gnt_idx); end
        tick();
        checks++; if (pend_cnt !== 7'd0) begin errors++; $display("FAIL sw_empty: got %0d expected 0", pend_cnt); end
    endtask

    task automatic test_flush();
        bit sawGnt;
        gnt_rdy = 1'b1;
        set_slot(6'd1);
        set_slot(6'd2);
        set_slot(6'd3);
        set_slot(6'd4);
        checks++; if (busy !== 1'b1 || pend_cnt !== 7'd4 || gnt_vld !== 1'b0) begin errors++; $display("FAIL flush_pre: busy %b cnt %0d vld %b expected 1 4 0", busy, pend_cnt, gnt_vld); end
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        checks++; if (busy !== 1'b0 || pend_cnt !== 7'd0) begin errors++; $display("FAIL flush_post: busy %b cnt %0d expected 0 0", busy, pend_cnt); end
        checks++; if (pe_oht !== 64'h2 || err !== 1'b0) begin errors++; $display("FAIL flush_keep: oht %h err %b expected 2 0", pe_oht, err); end
        sawGnt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (gnt_vld !== 1'b0 || busy !== 1'b0) sawGnt = 1'b1;
            tick();
        end
        checks++; if (sawGnt) begin errors++; $display("FAIL flush_quiet: got activity expected none"); end
    endtask

    task automatic test_contract_err();
        bit ok;
        bit sawGnt;
        int stamp;
        forceBad = 1'b1;
        gnt_rdy = 1'b1;
        set_slot(6'd9);
        ok = 1'b0;
        sawGnt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (err === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (gnt_vld) sawGnt = 1'b1;
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL err_raise: err %b expected 1", err); end
        checks++; if (sawGnt || gnt_vld !== 1'b0) begin errors++; $display("FAIL err_no_gnt: got grant expected none"); end
        checks++; if (busy !== 1'b0 || pend_cnt !== 7'd1) begin errors++; $display("FAIL err_idle: busy %b cnt %0d expected 0 1", busy, pend_cnt); end
        tick();
        checks++; if (busy !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL err_relaunch: busy %b err %b expected 1 1", busy, err); end
        forceBad = 1'b0;
        wait_gnt(20, ok, stamp);
        checks++; if (!ok || gnt_idx !== 6'd9 || err !== 1'b1) begin errors++; $display("FAIL err_recover: ok %0d idx %0d err %b expected 1 9 1", ok, gnt_idx, err); end
        tick();
        checks++; if (pend_cnt !== 7'd0) begin errors++; $display("FAIL err_empty: got %0d expected 0", pend_cnt); end
    endtask

    task automatic test_reset_in_offer();
        bit ok;
        int stamp;
        gnt_rdy = 1'b0;
        set_slot(6'd7);
        wait_gnt(20, ok, stamp);
        checks++; if (!ok || gnt_idx !== 6'd7) begin errors++; $display("FAIL rst_offer_pre: ok %0d idx %0d expected 1 7", ok, gnt_idx); end
        #2 rst = 1'b1;
        #1;
        checks++; if (gnt_vld !== 1'b0 || gnt_idx !== '0 || pe_oht !== '0) begin errors++; $display("FAIL rst_offer_gnt: vld %b idx %0d oht %h expected 0 0 0", gnt_vld, gnt_idx, pe_oht); end
        checks++; if (pend_cnt !== '0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_offer_state: cnt %0d busy %b err %b expected 0 0 0", pend_cnt, busy, err); end
        tick();
        rst = 1'b0;
        gnt_rdy = 1'b1;
        repeat (PE_LAT + 4) tick();
        checks++; if (gnt_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_offer_discard: vld %b busy %b expected 0 0", gnt_vld, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ordering();
        test_backpressure();
        test_set_wins();
        test_flush();
        test_contract_err();
        test_reset_in_offer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
